// File: rtl/conv_arbiter.sv
// Round-robin arbiter in front of a shared sign-magnitude to two's-complement converter.
// Requesters hand over operands via valid/ready; results come back with the owner's id.
module conv_arbiter #(
    parameter int BITS  = 32,
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*BITS-1:0]  i_req_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BITS-1:0]        o_result,
    output logic                   o_error,
    output logic [IDW-1:0]         o_id,
    output logic                   o_busy,
    output logic [CNT_W-1:0]       o_err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant;
    logic            any_valid;
    logic            accept;
    logic [BITS-1:0] op_reg;
    logic [IDW-1:0]  id_reg;
    logic [BITS-2:0] mag;
    logic [BITS-1:0] conv_result;
    logic            conv_error;
    logic            out_fire;

    // First valid requester strictly after the last winner, wrapping around.
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!any_valid && i_req_valid[(int'(ptr) + i) % N_REQ]) begin
                any_valid = 1'b1;
                grant     = IDW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    // A reset cycle must never complete a handshake, even though state already reads IDLE.
    assign accept      = (state == IDLE) && any_valid && !i_rst;
    assign o_req_ready = accept ? (N_REQ'(1) << grant) : '0;
    assign out_fire    = (state == OUT) && i_ready;
    assign o_valid     = (state == OUT);
    assign o_busy      = (state != IDLE);

    assign mag = op_reg[BITS-2:0];

    // Negative zero has no distinct two's-complement encoding, so it maps to 0 and is flagged.
    always_comb begin
        conv_result = op_reg;
        conv_error  = 1'b0;
        if (op_reg[BITS-1]) begin
            if (mag == '0) begin
                conv_result = '0;
                conv_error  = 1'b1;
            end else begin
                conv_result = ~{1'b0, mag} + BITS'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    state_next = OUT;
            OUT:     if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            ptr         <= IDW'(N_REQ - 1);
            o_result    <= '0;
            o_error     <= 1'b0;
            o_id        <= '0;
            o_err_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ptr <= grant;
            end
            if (state == CONV) begin
                o_result <= conv_result;
                o_error  <= conv_error;
                o_id     <= id_reg;
            end
            if (out_fire && o_error && (o_err_count != '1)) begin
                o_err_count <= o_err_count + CNT_W'(1);
            end
        end
    end

    // NOTE: the operand latch is pure datapath and needs no reset; it is only read in CONV,
    // which can only be reached through a fresh accept.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_reg <= i_req_data[int'(grant)*BITS +: BITS];
            id_reg <= grant;
        end
    end

endmodule

// File: doc/conv_arbiter.md
Name: conv_arbiter

Overview:
Shares one ZM→U2 conversion datapath between N_REQ requesters.
- Each requester offers a sign-magnitude operand over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The operand is latched and converted, and the registered U2 result is returned with the requester id and an error flag.
- The block sits between operand sources (register file / test stimulus) and the synchronous arithmetic unit's result bus.

Parameters:
BITS, 32, operand/result width.
N_REQ, 2, number of requesters (≥2).
IDW, $clog2(N_REQ), width of requester id.
CNT_W, 16, width of the saturating error counter.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous reset, active-high.
i_req_valid  input  N_REQ  bit k: requester k offers an operand.
o_req_ready  output  N_REQ  bit k: operand k accepted this cycle (one-hot or zero).
i_req_data  input  N_REQ*BITS  requester k operand in [k*BITS +: BITS], ZM code.
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts result.
o_result  output  BITS  U2 result.
o_error  output  1  operand was negative zero.
o_id  output  IDW  index of requester that owns the result.
o_busy  output  1  high whenever state ≠ IDLE.
o_err_count  output  CNT_W  saturating count of error results delivered.

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE, o_valid=0, o_result=0, o_error=0, o_id=0, o_err_count=0, round-robin pointer=N_REQ-1 (requester 0 has top priority first).
- Reset mid-operation discards the latched operand and any pending result. No handshake completes in the reset cycle.
- FSM states: IDLE, CONV, OUT.
- IDLE:
  - If any i_req_valid bit is set, grant the first set bit searching upward from pointer+1, wrapping modulo N_REQ.
  - o_req_ready[grant]=1 combinationally in that cycle only.
  - Latch i_req_data[grant] and the grant id; set pointer=grant; go to CONV.
  - Otherwise stay in IDLE with o_req_ready=0.
- CONV: apply the conversion to the latched operand, register o_result, o_error and o_id, set o_valid=1, go to OUT.
- OUT:
  - o_valid, o_result, o_error and o_id are held stable until i_ready=1.
  - On the handshake cycle (o_valid & i_ready), go to IDLE; o_valid=0 from the next cycle.
  - If o_error=1 on the handshake, increment o_err_count, saturating at 2^CNT_W-1.
- o_req_ready is always 0 outside IDLE.
- Latency: accept at edge t → o_valid=1 after edge t+1, i.e. 2 cycles.
- Throughput: one operation per 3 cycles with i_ready held high.
- Conversion rules, where x is the latched operand and mag=x[BITS-2:0]:
  - x[BITS-1]=0: o_result=x, o_error=0.
  - x[BITS-1]=1 and mag≠0: o_result=(~{1'b0,mag})+1, i.e. −mag in U2; o_error=0.
  - x[BITS-1]=1 and mag=0 (negative zero): o_result=0, o_error=1.
- The valid range is ±(2^(BITS-1)−1); no overflow case exists.
- Requester valid dropping before it is granted is legal; that requester is simply not granted.
- The data of an ungranted requester is ignored.
- Simultaneous requests: exactly one is granted per IDLE cycle. Under continuous contention each requester is served once per N_REQ grants.

Test Plan:
1. Reset, then req0 valid with 0x0000_0005 → o_req_ready=01 for one cycle; 2 cycles later o_valid=1, o_result=0x0000_0005, o_error=0, o_id=0.
2. req1 alone with 0x8000_0005 → o_result=0xFFFF_FFFB, o_id=1. Repeat with 0xFFFF_FFFF → o_result=0x8000_0001.
3. req0 with 0x8000_0000 → o_error=1, o_result=0; after the handshake o_err_count=1. A second negative zero gives o_err_count=2.
4. Both requesters held valid (req0=0x0000_0001, req1=0x8000_0001), i_ready=1 → grants alternate 0,1,0,1; results alternate 0x0000_0001 / 0xFFFF_FFFF with matching o_id; one result every 3 cycles.
5. i_ready=0 for 5 cycles while in OUT → o_valid, o_result, o_id stable and o_req_ready=00 throughout. i_ready=1 → o_valid falls next cycle and o_busy=0.
6. i_rst asserted during CONV → next cycle o_valid=0, o_busy=0, o_err_count=0, pointer reset. A following req1 request is still granted normally, and req0 wins if both requesters are valid.
